// File: rtl/set_job_dispatcher_pkg.sv
// Shared encodings, field widths and FSM states for the SET job dispatcher.
package set_pkg;

    localparam int CENT_W = 24;
    localparam int RAD_W  = 12;
    localparam int CNT_W  = 8;
    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_A   = 2'd0,
        MODE_AND = 2'd1,
        MODE_XOR = 2'd2,
        MODE_ILL = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_ILL = 2'b01,
        ERR_TMO = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESULT
    } state_e;

    typedef struct packed {
        logic [CENT_W-1:0] central;
        logic [RAD_W-1:0]  radius;
        logic [MODE_W-1:0] mode;
    } job_op_t;

endpackage

// File: rtl/set_job_dispatcher_fifo.sv
// Synchronous job FIFO with an occupancy counter one bit wider than the pointers.
module set_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/set_job_dispatcher.sv
// Queues SET jobs, issues one set_en per legal job, watchdogs it and returns a tagged result.
module set_job_dispatcher
    import set_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [CENT_W-1:0]      job_central,
    input  logic [RAD_W-1:0]       job_radius,
    input  logic [MODE_W-1:0]      job_mode,
    output logic                   set_en,
    output logic [CENT_W-1:0]      set_central,
    output logic [RAD_W-1:0]       set_radius,
    output logic [MODE_W-1:0]      set_mode,
    input  logic                   set_busy,
    input  logic                   set_valid,
    input  logic [CNT_W-1:0]       set_candidate,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CNT_W-1:0]       res_candidate,
    output logic [TAG_W-1:0]       res_tag,
    output logic [1:0]             res_err,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int FIFO_W = $bits(job_op_t) + TAG_W;

    logic              push, pop, full, empty;
    logic [FIFO_W-1:0] fifo_din, fifo_dout;
    job_op_t           head_op, op_q;
    logic [TAG_W-1:0]  head_tag, tag_q, tag_cnt;
    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              set_en_d, res_valid_d;
    logic [CNT_W-1:0]  res_cand_d;
    logic [1:0]        res_err_d;

    assign job_ready = ~full;
    assign push      = job_valid & ~full;
    assign fifo_din  = {tag_cnt, job_central, job_radius, job_mode};
    assign {head_tag, head_op} = fifo_dout;

    set_job_fifo #(.DEPTH(DEPTH), .WIDTH(FIFO_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign set_central = op_q.central;
    assign set_radius  = op_q.radius;
    assign set_mode    = op_q.mode;
    assign res_tag     = tag_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_d     = state_q;
        timer_d     = timer_q;
        pop         = 1'b0;
        set_en_d    = 1'b0;
        res_valid_d = res_valid;
        res_cand_d  = res_candidate;
        res_err_d   = res_err;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    // Illegal mode would stall SET, so it is answered without ever issuing.
                    if (mode_e'(head_op.mode) == MODE_ILL) begin
                        state_d     = S_RESULT;
                        res_valid_d = 1'b1;
                        res_cand_d  = '0;
                        res_err_d   = ERR_ILL;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!set_busy) begin
                    set_en_d = 1'b1;
                    timer_d  = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (set_valid) begin
                    state_d     = S_RESULT;
                    res_valid_d = 1'b1;
                    res_cand_d  = set_candidate;
                    res_err_d   = ERR_OK;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    state_d     = S_RESULT;
                    res_valid_d = 1'b1;
                    res_cand_d  = '0;
                    res_err_d   = ERR_TMO;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            set_en        <= 1'b0;
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_err       <= '0;
            op_q          <= '0;
            tag_q         <= '0;
            tag_cnt       <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            set_en        <= set_en_d;
            res_valid     <= res_valid_d;
            res_candidate <= res_cand_d;
            res_err       <= res_err_d;
            if (pop) begin
                op_q  <= head_op;
                tag_q <= head_tag;
            end
            if (push) tag_cnt <= tag_cnt + TAG_W'(1);
        end
    end

endmodule
